// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the in-order MIPS core pipeline control:
// the control state encoding and the default address/vector constants.
package cpu_defs;

  localparam int          CPU_ADDR_W  = 32;
  localparam logic [31:0] CPU_EXC_VEC = 32'h0000_0020;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_unit_stall_mask_gen.sv
// Priority-prefix stall mask: the highest stalling stage freezes itself
// and every stage in front of it, down to the PC.
module stall_mask_gen
  import cpu_defs::*;
#(
  parameter int NSTAGE = 6
) (
  input  logic [NSTAGE-1:0] stall_req,
  output logic [NSTAGE-1:0] stall_mask
);

  // Bit i is held whenever any stage at or beyond i asks to stall.
  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_bit
      assign stall_mask[gi] = |stall_req[NSTAGE-1:gi];
    end
  endgenerate

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for the in-order MIPS core: stall mask, exception/ERET
// flush and redirect sequencing, EPC capture, stall watchdog and stall counter.
module pipe_ctrl_unit
  import cpu_defs::*;
#(
  parameter int          NSTAGE    = 6,
  parameter int          ADDR_W    = CPU_ADDR_W,
  parameter logic [31:0] EXC_VEC   = CPU_EXC_VEC,
  parameter int          FLUSH_CYC = 1,
  parameter int          WDOG_MAX  = 255,
  parameter int          CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic              exc_valid,
  input  logic              exc_is_eret,
  input  logic [ADDR_W-1:0] exc_epc,
  output logic [NSTAGE-1:0] stall_en,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              new_pc_valid,
  output logic [ADDR_W-1:0] epc,
  output logic              stall_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int FC_W = $clog2(FLUSH_CYC + 1);
  localparam int WD_W = $clog2(WDOG_MAX + 1);

  localparam logic [FC_W-1:0]   FC_LOAD = FC_W'(FLUSH_CYC - 1);
  localparam logic [WD_W-1:0]   WD_TOP  = WD_W'(WDOG_MAX);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(WDOG_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_TOP = '1;
  localparam logic [ADDR_W-1:0] EXC_PC  = ADDR_W'(EXC_VEC);

  state_e            state_reg;
  logic [FC_W-1:0]   flush_cnt_reg;
  logic [WD_W-1:0]   wd_reg;
  logic [ADDR_W-1:0] new_pc_reg;
  logic [ADDR_W-1:0] epc_reg;
  logic              new_pc_valid_reg;
  logic              timeout_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic [NSTAGE-1:0] stall_mask;
  logic              in_run;
  logic              accept;
  logic              count_stall;

  stall_mask_gen #(
    .NSTAGE(NSTAGE)
  ) u_mask (
    .stall_req (stall_req),
    .stall_mask(stall_mask)
  );

  assign in_run   = (state_reg == RUN);
  assign stall_en = (in_run && !reset) ? stall_mask : '0;
  assign accept   = in_run && exc_valid;

  // An accepted exception outranks a coincident stall for the counters,
  // even though stall_en still shows the request on that cycle.
  assign count_stall = (|stall_en) && !accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= RUN;
      flush_cnt_reg    <= '0;
      new_pc_valid_reg <= 1'b0;
      new_pc_reg       <= '0;
      epc_reg          <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          new_pc_valid_reg <= 1'b0;
          if (exc_valid) begin
            state_reg        <= FLUSH;
            flush_cnt_reg    <= FC_LOAD;
            new_pc_valid_reg <= 1'b1;
            // ERET returns to the EPC saved before this event, not exc_epc.
            if (exc_is_eret) begin
              new_pc_reg <= epc_reg;
            end else begin
              new_pc_reg <= EXC_PC;
              epc_reg    <= exc_epc;
            end
          end
        end
        FLUSH: begin
          new_pc_valid_reg <= 1'b0;
          if (flush_cnt_reg == '0) begin
            state_reg <= RUN;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg        <= RUN;
          new_pc_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog: counts consecutive stalled RUN cycles; the flag is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else if (count_stall) begin
      if (wd_reg != WD_TOP) begin
        wd_reg <= wd_reg + 1'b1;
      end
      if (wd_reg >= WD_LAST) begin
        timeout_reg <= 1'b1;
      end
    end else begin
      wd_reg <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (count_stall && (stall_cnt_reg != CNT_TOP)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign flush         = (state_reg == FLUSH);
  assign new_pc        = new_pc_reg;
  assign new_pc_valid  = new_pc_valid_reg;
  assign epc           = epc_reg;
  assign stall_timeout = timeout_reg;
  assign stall_cnt     = stall_cnt_reg;

endmodule
